// File: rtl/syn_debug_scanner.sv
// Debug snapshot scanner: streams a byte frame of 0xA5, pc, r0..r31 and a data-memory window.
// Optional trailing checksum byte when SCANNER_CHECKSUM_EN is defined.
module syn_debug_scanner #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dm_base,
    input  logic [7:0]        dm_count,
    input  logic              run,
    output logic              cpu_en,
    input  logic [31:0]       pc_dbg,
    output logic [4:0]        regfile_req_dbg,
    input  logic [31:0]       regfile_data_dbg,
    output logic [ADDR_W-1:0] datamem_addr_dbg,
    input  logic [31:0]       datamem_data_dbg,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, HDR, SAMPLE, SEND, CSUM, FIN} state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        count_q, count_d;
    logic [8:0]        item_q, item_d;
    logic [1:0]        byte_q, byte_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [4:0]        regfile_req_q, regfile_req_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
`ifdef SCANNER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        hs;
    logic [8:0]  next_item;
    logic [8:0]  last_item;
    logic [31:0] sample_word;

    // Item 0 is the pc, items 1..32 are registers, the rest are memory words.
    assign hs          = tx_valid_q & tx_ready;
    assign next_item   = item_q + 9'd1;
    assign last_item   = 9'd32 + {1'b0, count_q};
    assign sample_word = (item_q == 9'd0)  ? pc_dbg :
                         (item_q <= 9'd32) ? regfile_data_dbg : datamem_data_dbg;

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        count_d       = count_q;
        item_d        = item_q;
        byte_d        = byte_q;
        shift_d       = shift_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        regfile_req_d = regfile_req_q;
        dm_addr_d     = dm_addr_q;
`ifdef SCANNER_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d     = dm_base;
                    count_d    = dm_count;
                    tx_data_d  = HDR_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = HDR;
`ifdef SCANNER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            HDR: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    item_d     = 9'd0;
                    state_d    = SAMPLE;
                end
            end
            SAMPLE: begin
                // Debug address has been stable all cycle; capture the response now.
                tx_data_d  = sample_word[31:24];
                shift_d    = sample_word[23:0];
                tx_valid_d = 1'b1;
                byte_d     = 2'd0;
                state_d    = SEND;
            end
            SEND: begin
                if (hs) begin
`ifdef SCANNER_CHECKSUM_EN
                    csum_d = csum_q + tx_data_q;
`endif
                    if (byte_q != 2'd3) begin
                        byte_d    = byte_q + 2'd1;
                        tx_data_d = shift_q[23:16];
                        shift_d   = {shift_q[15:0], 8'h00};
                    end else if (item_q == last_item) begin
`ifdef SCANNER_CHECKSUM_EN
                        tx_data_d = csum_q + tx_data_q;
                        state_d   = CSUM;
`else
                        tx_valid_d = 1'b0;
                        state_d    = FIN;
`endif
                    end else begin
                        tx_valid_d = 1'b0;
                        item_d     = next_item;
                        state_d    = SAMPLE;
                        if (next_item <= 9'd32) begin
                            regfile_req_d = 5'(next_item - 9'd1);
                        end else if (next_item == 9'd33) begin
                            dm_addr_d = base_q;
                        end else begin
                            dm_addr_d = dm_addr_q + ADDR_W'(1);
                        end
                    end
                end
            end
`ifdef SCANNER_CHECKSUM_EN
            CSUM: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = FIN;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            base_q        <= '0;
            count_q       <= '0;
            item_q        <= '0;
            byte_q        <= '0;
            shift_q       <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            regfile_req_q <= '0;
            dm_addr_q     <= '0;
`ifdef SCANNER_CHECKSUM_EN
            csum_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            count_q       <= count_d;
            item_q        <= item_d;
            byte_q        <= byte_d;
            shift_q       <= shift_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            regfile_req_q <= regfile_req_d;
            dm_addr_q     <= dm_addr_d;
`ifdef SCANNER_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign tx_data          = tx_data_q;
    assign tx_valid         = tx_valid_q;
    assign regfile_req_dbg  = regfile_req_q;
    assign datamem_addr_dbg = dm_addr_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == FIN);
    assign cpu_en           = run & ~busy;

endmodule

// File: tb/tb_syn_debug_scanner.sv
// Directed bench for syn_debug_scanner: vector table of frames plus reset-abort sequence.
// Frame length and checksum expectations follow SCANNER_CHECKSUM_EN.
module tb_syn_debug_scanner;

`ifdef SCANNER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int LIMIT = 5000;

    logic        clk = 1'b0;
    logic        rst, start, run, cpu_en;
    logic [9:0]  dm_base, datamem_addr_dbg;
    logic [7:0]  dm_count, tx_data;
    logic [31:0] pc_dbg, regfile_data_dbg, datamem_data_dbg;
    logic [4:0]  regfile_req_dbg;
    logic        tx_valid, tx_ready, busy, done;

    logic [31:0] regs [32];
    logic [31:0] mem  [1024];

    assign regfile_data_dbg = regs[regfile_req_dbg];
    assign datamem_data_dbg = mem[datamem_addr_dbg];

    always #5 clk = ~clk;

    syn_debug_scanner #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .dm_base(dm_base), .dm_count(dm_count),
        .run(run), .cpu_en(cpu_en), .pc_dbg(pc_dbg),
        .regfile_req_dbg(regfile_req_dbg), .regfile_data_dbg(regfile_data_dbg),
        .datamem_addr_dbg(datamem_addr_dbg), .datamem_data_dbg(datamem_data_dbg),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    int tests = 0;
    int fails = 0;
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    logic [7:0] ref0[$];

    typedef struct {
        logic [9:0] base;
        logic [7:0] cnt;
        int         stall;
        bit         mid;
        int         exp_len;
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic build_exp(input logic [9:0] base, input logic [7:0] cnt);
        logic [31:0] w;
        logic [7:0]  s;
        logic [9:0]  a;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        s = 8'h00;
        for (int i = 0; i < 33 + int'(cnt); i++) begin
            if (i == 0) w = pc_dbg;
            else if (i <= 32) w = regs[i-1];
            else begin
                a = base + 10'(i - 33);
                w = mem[a];
            end
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[b*8 +: 8]);
                s = s + w[b*8 +: 8];
            end
        end
        if (CK == 1) exp_q.push_back(s);
    endtask

    task automatic run_frame(input logic [9:0] base, input logic [7:0] cnt, input int stall,
                             input bit mid, output int dones, output int bad_busy,
                             output int bad_stall, output bit got_done);
        bit         prev_stall;
        logic [7:0] prev_data;
        int         cyc;
        rx.delete();
        dones = 0; bad_busy = 0; bad_stall = 0; got_done = 1'b0;
        prev_stall = 1'b0; prev_data = 8'h00; cyc = 0;
        @(negedge clk);
        dm_base = base; dm_count = cnt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dm_base = ~base; dm_count = cnt + 8'd7;
        while (!got_done && cyc < LIMIT) begin
            if (cyc > 0) @(negedge clk);
            start = mid && (cyc == 20);
            tx_ready = ($urandom_range(99) >= stall);
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) bad_stall++;
            if (!busy || cpu_en) bad_busy++;
            if (done) begin
                dones++;
                got_done = 1'b1;
            end
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            cyc++;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
            if (tx_valid) bad_stall++;
        end
        if (busy) bad_busy++;
        tx_ready = 1'b0;
    endtask

    int  dones, bad_busy, bad_stall, mism, nb, cyc, leak;
    bit  got_done;
    logic [7:0] s8;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i * 32'h0102_0304;
        regs[5] = 32'hDEADBEEF;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 ^ (i * 32'h0001_0203);
        mem[10'h3FF] = 32'h11223344;
        mem[10'h000] = 32'h55667788;

        vt[0] = '{10'h00A, 8'd2, 0,  1'b0, 141 + CK};
        vt[1] = '{10'h00A, 8'd2, 30, 1'b1, 141 + CK};
        vt[2] = '{10'h3FF, 8'd2, 0,  1'b0, 141 + CK};
        vt[3] = '{10'h005, 8'd0, 0,  1'b1, 133 + CK};
        vt[4] = '{10'h100, 8'd5, 50, 1'b0, 153 + CK};

        rst = 1'b1; start = 1'b0; run = 1'b1; tx_ready = 1'b0;
        dm_base = '0; dm_count = '0; pc_dbg = 32'h00000C34;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_reg_idx", {27'd0, regfile_req_dbg}, 32'd0);
        check("rst_dm_addr", {22'd0, datamem_addr_dbg}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd1);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            run_frame(vt[v].base, vt[v].cnt, vt[v].stall, vt[v].mid,
                      dones, bad_busy, bad_stall, got_done);
            build_exp(vt[v].base, vt[v].cnt);
            check($sformatf("v%0d_done_seen", v), {31'd0, got_done}, 32'd1);
            check($sformatf("v%0d_len", v), rx.size(), vt[v].exp_len);
            check($sformatf("v%0d_byte0", v), {24'd0, rx[0]}, 32'hA5);
            check($sformatf("v%0d_done_pulses", v), dones, 32'd1);
            check($sformatf("v%0d_busy_cpu_en", v), bad_busy, 32'd0);
            check($sformatf("v%0d_stall_hold", v), bad_stall, 32'd0);
            mism = 0;
            for (int i = 0; i < exp_q.size(); i++) if (rx[i] !== exp_q[i]) mism++;
            check($sformatf("v%0d_frame_bytes", v), mism, 32'd0);
            if (v == 0) begin
                ref0 = rx;
                check("v0_pc_bytes", {rx[1], rx[2], rx[3], rx[4]}, 32'h00000C34);
                check("v0_r5_bytes", {rx[25], rx[26], rx[27], rx[28]}, 32'hDEADBEEF);
            end
            if (v == 1) begin
                mism = (rx.size() == ref0.size()) ? 0 : 1;
                for (int i = 0; i < ref0.size(); i++) if (rx[i] !== ref0[i]) mism++;
                check("v1_same_as_ready1", mism, 32'd0);
            end
            if (v == 2) begin
                check("v2_mem_3ff", {rx[133], rx[134], rx[135], rx[136]}, 32'h11223344);
                check("v2_mem_000", {rx[137], rx[138], rx[139], rx[140]}, 32'h55667788);
            end
`ifdef SCANNER_CHECKSUM_EN
            if (v == 3) begin
                s8 = 8'h00;
                for (int i = 1; i <= 132; i++) s8 = s8 + rx[i];
                check("v3_checksum", {24'd0, rx[133]}, {24'd0, s8});
            end
`endif
        end

        // Abort a frame with reset after 50 accepted bytes, then confirm a clean restart.
        @(negedge clk);
        dm_base = 10'h00A; dm_count = 8'd2; start = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0; cyc = 0;
        while (nb < 50 && cyc < LIMIT) begin
            if (cyc > 0) @(negedge clk);
            if (tx_valid && tx_ready) nb++;
            cyc++;
        end
        check("abort_reached_50", nb, 32'd50);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        leak = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx_valid || busy) leak++;
        end
        check("abort_no_resume", leak, 32'd0);
        run_frame(10'h00A, 8'd2, 0, 1'b0, dones, bad_busy, bad_stall, got_done);
        check("restart_len", rx.size(), 141 + CK);
        check("restart_byte0", {24'd0, rx[0]}, 32'hA5);
        check("restart_done_pulses", dones, 32'd1);
        mism = (rx.size() == ref0.size()) ? 0 : 1;
        for (int i = 0; i < ref0.size(); i++) if (rx[i] !== ref0[i]) mism++;
        check("restart_frame_bytes", mism, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
